button_pulse_gen: RTL and testbench

Debounced pushbutton front end that produces the `increment` strobe consumed by the digit counter. The raw active-low pad is synchronised, debounced and turned into single-cycle press, release and auto-repeat pulses. It also produces an active-low `increment` output, so the counter advances once per clean press and at a fixed rate while the button is held.

---
 rtl/button_pkg.sv | 22 ++
 rtl/btn_sync.sv | 20 ++
 rtl/button_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_button_pulse_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the pushbutton front end.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_e;

    // Counter width wide enough for the largest of the three timing parameters.
    function automatic int unsigned cnt_w(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous pad, with a selectable reset level.
module btn_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) sync_q <= {2{RST_VAL}};
        else         sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced pushbutton front end: press/release/auto-repeat strobes plus an
// active-low increment strobe for the digit counter.
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic increment
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic pad_s;

    // Pad idles released (high) so reset never looks like a press.
    btn_sync #(.RST_VAL(1'b1)) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (btn_n),
        .q_o    (pad_s)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] db_q, db_d;
    logic [CW-1:0] rpt_q, rpt_d;
    logic          first_q, first_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          rep_q, rep_d;

    logic [CW-1:0] rpt_last;
    logic          rpt_exp;
    logic          db_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            db_q    <= '0;
            rpt_q   <= '0;
            first_q <= 1'b1;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            db_q    <= db_d;
            rpt_q   <= rpt_d;
            first_q <= first_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        db_d     = db_q;
        rpt_d    = rpt_q;
        first_d  = first_q;
        level_d  = level_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        rep_d    = 1'b0;
        rpt_last = first_q ? RD_LAST : RP_LAST;
        rpt_exp  = (rpt_q >= rpt_last);
        db_done  = (db_q >= DB_LAST);

        unique case (state_q)
            IDLE: begin
                if (!pad_s) begin
                    state_d = PRESS_DB;
                    db_d    = '0;
                end
            end
            PRESS_DB: begin
                if (pad_s) begin
                    state_d = IDLE;
                end else if (db_done) begin
                    state_d = HELD;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    rpt_d   = '0;
                    first_d = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HELD: begin
                // A release seen on an expiry edge freezes the timer at expiry,
                // so the pulse is taken on the next HELD cycle instead.
                if (pad_s) begin
                    state_d = REL_DB;
                    db_d    = '0;
                end else if (REPEAT_EN) begin
                    if (rpt_exp) begin
                        rep_d   = 1'b1;
                        rpt_d   = '0;
                        first_d = 1'b0;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
            REL_DB: begin
                if (!pad_s) begin
                    state_d = HELD;
                end else if (db_done) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign repeat_pulse  = rep_q;
    assign increment     = ~(press_q | rep_q);

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen with DEBOUNCE=4, DELAY=10, PERIOD=3.
module tb_button_pulse_gen;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_n = 1'b1;

    logic lv, pr, rl, rp, ic;
    logic lv2, pr2, rl2, rp2, ic2;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .btn_level(lv), .press_pulse(pr), .release_pulse(rl),
        .repeat_pulse(rp), .increment(ic)
    );

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b0)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .btn_level(lv2), .press_pulse(pr2), .release_pulse(rl2),
        .repeat_pulse(rp2), .increment(ic2)
    );

    always #5 clk = ~clk;

    // Per-edge stimulus and observed {level, press, release, repeat, increment}.
    logic       pad  [N];
    logic       rstv [N];
    logic [4:0] obs  [N];
    logic [4:0] obs2 [N];

    int passed = 0;
    int total  = 0;

    function automatic logic [4:0] mk(input logic l, input logic p,
                                      input logic r, input logic rep);
        return {l, p, r, rep, ~(p | rep)};
    endfunction

    task automatic set_pad(input int lo_from, input int lo_to);
        for (int k = 0; k < N; k++) begin
            pad[k]  = !(k >= lo_from && k <= lo_to);
            rstv[k] = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            btn_n = pad[k];
            rst   = rstv[k];
            @(posedge clk);
            #1;
            obs[k]  = {lv, pr, rl, rp, ic};
            obs2[k] = {lv2, pr2, rl2, rp2, ic2};
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        btn_n = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        btn_n = 1'b0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({lv, pr, rl, rp, ic} !== 5'b00001)
            $display("FAIL reset_state: got %b expected %b", {lv, pr, rl, rp, ic}, 5'b00001);
        else passed++;
        total++;
        if ({lv2, pr2, rl2, rp2, ic2} !== 5'b00001)
            $display("FAIL reset_state_nr: got %b expected %b", {lv2, pr2, rl2, rp2, ic2}, 5'b00001);
        else passed++;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if ({lv, pr, rl, rp, ic} !== 5'b00001)
            $display("FAIL reset_hold_pad_low: got %b expected %b", {lv, pr, rl, rp, ic}, 5'b00001);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_clean_press();
        logic [4:0] e;
        do_reset();
        set_pad(0, 11);
        run(24);
        for (int k = 0; k < 24; k++) begin
            e = mk(k >= 6 && k < 18, k == 6, k == 18, 1'b0);
            total++;
            if (obs[k] !== e)
                $display("FAIL clean_press edge %0d: got %b expected %b", k, obs[k], e);
            else passed++;
        end
    endtask

    task automatic test_bounce();
        logic [4:0] e;
        do_reset();
        set_pad(0, 2);
        pad[4] = 1'b0;
        pad[5] = 1'b0;
        run(16);
        e = mk(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (obs[k] !== e)
                $display("FAIL bounce edge %0d: got %b expected %b", k, obs[k], e);
            else passed++;
        end
    endtask

    task automatic test_repeat();
        logic [4:0] e;
        logic [4:0] e2;
        do_reset();
        set_pad(0, N - 1);
        run(28);
        for (int k = 0; k < 28; k++) begin
            e  = mk(k >= 6, k == 6, 1'b0, k == 16 || k == 19 || k == 22 || k == 25);
            e2 = mk(k >= 6, k == 6, 1'b0, 1'b0);
            total++;
            if (obs[k] !== e)
                $display("FAIL repeat edge %0d: got %b expected %b", k, obs[k], e);
            else passed++;
            total++;
            if (obs2[k] !== e2)
                $display("FAIL repeat_disabled edge %0d: got %b expected %b", k, obs2[k], e2);
            else passed++;
        end
    endtask

    // Pad blips high so the synchronised release lands on the first expiry edge.
    task automatic test_expiry_collision();
        logic [4:0] e;
        logic [4:0] e2;
        do_reset();
        set_pad(0, N - 1);
        pad[14] = 1'b1;
        run(26);
        for (int k = 0; k < 26; k++) begin
            e  = mk(k >= 6, k == 6, 1'b0, k == 18 || k == 21 || k == 24);
            e2 = mk(k >= 6, k == 6, 1'b0, 1'b0);
            total++;
            if (obs[k] !== e)
                $display("FAIL expiry_collision edge %0d: got %b expected %b", k, obs[k], e);
            else passed++;
            total++;
            if (obs2[k] !== e2)
                $display("FAIL expiry_collision_nr edge %0d: got %b expected %b", k, obs2[k], e2);
            else passed++;
        end
    endtask

    task automatic test_release_bounce();
        logic [4:0] e;
        do_reset();
        set_pad(0, 11);
        pad[14] = 1'b0;
        run(26);
        for (int k = 0; k < 26; k++) begin
            e = mk(k >= 6 && k < 21, k == 6, k == 21, 1'b0);
            total++;
            if (obs[k] !== e)
                $display("FAIL release_bounce edge %0d: got %b expected %b", k, obs[k], e);
            else passed++;
        end
    endtask

    task automatic test_reset_held();
        logic [4:0] e;
        do_reset();
        set_pad(0, N - 1);
        rstv[10] = 1'b0;
        run(26);
        for (int k = 0; k < 26; k++) begin
            e = mk((k >= 6 && k < 10) || k >= 17, k == 6 || k == 17, 1'b0, 1'b0);
            total++;
            if (obs[k] !== e)
                $display("FAIL reset_held edge %0d: got %b expected %b", k, obs[k], e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_expiry_collision();
        test_release_bounce();
        test_reset_held();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
